// File: rtl/sqsum_acc.sv
// Sum-of-squares accumulator: squares signed elements and accumulates with saturation,
// presenting the total on a valid/ready output held until consumed.
module sqsum_acc #(
  parameter int unsigned dataLen = 32,
  parameter int unsigned inLen   = 16,
  parameter int unsigned cntLen  = 8
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               start,
  input  logic [cntLen-1:0]  vec_len,
  input  logic [inLen-1:0]   data_in,
  input  logic               data_valid,
  output logic               ready,
  output logic [dataLen-1:0] sum_out,
  output logic               sat,
  output logic               out_valid,
  input  logic               out_ready
);

  localparam int unsigned SqW  = 2 * inLen;
  localparam int unsigned SumW = dataLen + 1;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ACCUM = 2'd1,
    HOLD  = 2'd2
  } state_e;

  state_e              state_q, state_d;
  logic [dataLen-1:0]  acc_q, acc_d;
  logic [cntLen-1:0]   cnt_q, cnt_d;
  logic                sat_q, sat_d;
  logic                ready_q, ready_d;
  logic                out_valid_q, out_valid_d;

  logic signed [inLen-1:0] din_s;
  logic signed [SqW-1:0]   prod;
  logic [SqW-1:0]          sq;
  logic [SumW-1:0]         sum_ext;
  logic                    accept;

  // Square is always non-negative, so the signed product reinterprets safely as unsigned.
  assign din_s   = data_in;
  assign prod    = din_s * din_s;
  assign sq      = $unsigned(prod);
  assign sum_ext = SumW'(acc_q) + SumW'(sq);
  assign accept  = ready_q && data_valid;

  always_comb begin
    state_d = state_q;
    acc_d   = acc_q;
    cnt_d   = cnt_q;
    sat_d   = sat_q;

    case (state_q)
      IDLE: begin
        if (start) begin
          acc_d   = '0;
          sat_d   = 1'b0;
          cnt_d   = vec_len;
          state_d = (vec_len != '0) ? ACCUM : HOLD;
        end
      end
      ACCUM: begin
        if (accept) begin
          // Carry out of the widened add means the true sum no longer fits.
          if (sum_ext[dataLen]) begin
            acc_d = '1;
            sat_d = 1'b1;
          end else begin
            acc_d = sum_ext[dataLen-1:0];
          end
          cnt_d = cnt_q - cntLen'(1);
          if (cnt_q == cntLen'(1)) begin
            state_d = HOLD;
          end
        end
      end
      HOLD: begin
        if (out_ready) begin
          state_d = IDLE;
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase

    ready_d     = (state_d == ACCUM);
    out_valid_d = (state_d == HOLD);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= IDLE;
      acc_q       <= '0;
      cnt_q       <= '0;
      sat_q       <= 1'b0;
      ready_q     <= 1'b0;
      out_valid_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      acc_q       <= acc_d;
      cnt_q       <= cnt_d;
      sat_q       <= sat_d;
      ready_q     <= ready_d;
      out_valid_q <= out_valid_d;
    end
  end

  assign ready     = ready_q;
  assign sum_out   = acc_q;
  assign sat       = sat_q;
  assign out_valid = out_valid_q;

endmodule

// File: tb/tb_sqsum_acc.sv
// Self-checking bench for sqsum_acc: directed and random vectors against a
// saturated prefix-sum-of-squares reference.
module tb_sqsum_acc;

  localparam int unsigned DW = 32;
  localparam int unsigned IW = 16;
  localparam int unsigned CW = 8;
  localparam longint unsigned MAXV = 64'h0000_0000_FFFF_FFFF;

  logic          clk = 1'b0;
  logic          reset;
  logic          start;
  logic [CW-1:0] vec_len;
  logic [IW-1:0] data_in;
  logic          data_valid;
  logic          ready;
  logic [DW-1:0] sum_out;
  logic          sat;
  logic          out_valid;
  logic          out_ready;

  int n_checks = 0;
  int n_fail   = 0;
  int vals[$];
  int vpat[$];

  sqsum_acc #(.dataLen(DW), .inLen(IW), .cntLen(CW)) dut (
    .clk        (clk),
    .reset      (reset),
    .start      (start),
    .vec_len    (vec_len),
    .data_in    (data_in),
    .data_valid (data_valid),
    .ready      (ready),
    .sum_out    (sum_out),
    .sat        (sat),
    .out_valid  (out_valid),
    .out_ready  (out_ready)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  function automatic longint unsigned satv(input longint unsigned s);
    return (s > MAXV) ? MAXV : s;
  endfunction

  // Runs the vector in vals (valid pattern from vpat, else random), then holds the
  // result for hold_cycles with start/data_valid noise before handshaking.
  task automatic run_vector(input string tag, input int hold_cycles);
    longint unsigned partial = 0;
    longint unsigned total   = 0;
    int idx    = 0;
    int budget = 0;
    foreach (vals[i]) total += longint'(vals[i]) * longint'(vals[i]);

    start   = 1'b1;
    vec_len = CW'(vals.size());
    step();
    start   = 1'b0;
    check({tag, "_ready_after_start"}, 64'(ready), 64'(vals.size() != 0));
    check({tag, "_sum_cleared"}, 64'(sum_out), 64'd0);

    while (idx < vals.size() && budget < 2000) begin
      budget++;
      if (vpat.size() > 0) data_valid = vpat.pop_front() != 0;
      else                 data_valid = $urandom_range(0, 3) != 0;
      data_in = data_valid ? IW'(vals[idx]) : IW'($urandom);
      step();
      if (data_valid) begin
        partial += longint'(vals[idx]) * longint'(vals[idx]);
        idx++;
      end
      check({tag, "_running_sum"}, 64'(sum_out), satv(partial));
      if (idx < vals.size()) check({tag, "_no_early_valid"}, 64'(out_valid), 64'd0);
    end
    data_valid = 1'b0;
    check({tag, "_all_accepted"}, 64'(idx), 64'(vals.size()));

    check({tag, "_out_valid"}, 64'(out_valid), 64'd1);
    check({tag, "_ready_low"}, 64'(ready), 64'd0);
    check({tag, "_sum"}, 64'(sum_out), satv(total));
    check({tag, "_sat"}, 64'(sat), 64'(total > MAXV));

    for (int c = 0; c < hold_cycles; c++) begin
      start      = 1'b1;
      vec_len    = CW'($urandom_range(1, 9));
      data_valid = 1'b1;
      data_in    = IW'($urandom);
      step();
      check({tag, "_hold_valid"}, 64'(out_valid), 64'd1);
      check({tag, "_hold_ready"}, 64'(ready), 64'd0);
      check({tag, "_hold_sum"}, 64'(sum_out), satv(total));
      check({tag, "_hold_sat"}, 64'(sat), 64'(total > MAXV));
    end
    start      = 1'b0;
    data_valid = 1'b0;
    out_ready  = 1'b1;
    step();
    out_ready  = 1'b0;
    check({tag, "_valid_dropped"}, 64'(out_valid), 64'd0);
    check({tag, "_idle_ready"}, 64'(ready), 64'd0);
    check({tag, "_idle_sum_kept"}, 64'(sum_out), satv(total));
    step();
    check({tag, "_idle_stays"}, 64'(out_valid), 64'd0);
  endtask

  initial begin
    logic signed [IW-1:0] t;
    reset = 1'b1; start = 1'b0; vec_len = '0; data_in = '0;
    data_valid = 1'b0; out_ready = 1'b0;
    repeat (3) step();
    check("rst_ready", 64'(ready), 64'd0);
    check("rst_out_valid", 64'(out_valid), 64'd0);
    check("rst_sum", 64'(sum_out), 64'd0);
    check("rst_sat", 64'(sat), 64'd0);
    reset = 1'b0;
    step();
    check("post_rst_idle", 64'(out_valid), 64'd0);

    // 1: small mixed-sign vector, back-to-back
    vals = '{1, 2, -3}; vpat = '{1, 1, 1};
    run_vector("t1", 0);
    // 2: sqrt-check value
    vals = '{256, 256}; vpat = '{1, 1};
    run_vector("t2", 1);
    // 3: most-negative element saturates on 4th accept
    vals = '{-32768, -32768, -32768, -32768, -32768}; vpat = '{1, 1, 1, 1, 1};
    run_vector("t3", 2);
    // 4: empty vector
    vals = {}; vpat = {};
    run_vector("t4", 0);
    // 5: bubbles plus long hold with start noise
    vals = '{3, 3, 3, 3}; vpat = '{1, 0, 1, 0, 1, 1};
    run_vector("t5", 5);

    // 6: reset mid-vector discards work
    start = 1'b1; vec_len = CW'(4); step(); start = 1'b0;
    data_valid = 1'b1; data_in = IW'(100);
    step(); step();
    data_valid = 1'b0;
    check("t6_partial", 64'(sum_out), 64'd20000);
    reset = 1'b1; step(); reset = 1'b0;
    check("t6_rst_ready", 64'(ready), 64'd0);
    check("t6_rst_valid", 64'(out_valid), 64'd0);
    check("t6_rst_sum", 64'(sum_out), 64'd0);
    check("t6_rst_sat", 64'(sat), 64'd0);
    repeat (3) begin
      data_valid = 1'b1; data_in = IW'($urandom);
      step();
      check("t6_no_valid", 64'(out_valid), 64'd0);
      check("t6_no_ready", 64'(ready), 64'd0);
    end
    data_valid = 1'b0;
    vals = '{1, 1}; vpat = '{1, 1};
    run_vector("t6b", 0);

    // Random vectors, every third biased to extremes to reach saturation
    for (int it = 0; it < 24; it++) begin
      int len;
      len = $urandom_range(0, 12);
      vals = {}; vpat = {};
      for (int k = 0; k < len; k++) begin
        if (it % 3 == 0) t = ($urandom_range(0, 1) != 0) ? IW'(16'sh8000 + IW'($urandom_range(0, 3000)))
                                                          : IW'(16'sh7FFF - IW'($urandom_range(0, 3000)));
        else             t = IW'($urandom);
        vals.push_back(int'(t));
      end
      run_vector("rnd", $urandom_range(0, 3));
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
